// File: rtl/dsp_sampler_pkg.sv
// Shared types, constants and helpers for the DSP product sampler.
// Imported by the sampler top; the byte transmitter is self-contained.
package dsp_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         BYTES_PER_CH = 32'sd9;

    // Sync byte, per-channel index + 8 data bytes, trailing checksum.
    function automatic int frame_len(input int num_ch);
        return num_ch * BYTES_PER_CH + 32'sd2;
    endfunction

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/dsp_byte_tx.sv
// Output byte register for the sampler frame: holds out_data/out_valid stable
// until the sink accepts, and reports each acceptance back to the sequencer.
module dsp_byte_tx (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       accepted
);

    logic [7:0] data_r;
    logic       valid_r;

    assign accepted  = valid_r & out_ready;
    assign out_data  = data_r;
    assign out_valid = valid_r;

    // A load may coincide with an acceptance, giving back-to-back bytes with no bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_byte;
            valid_r <= 1'b1;
        end else if (accepted) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/dsp_product_sampler.sv
// Snapshots NUM_CH 64-bit DSP products after a settle delay and streams them
// as a checksummed byte frame over a valid/ready interface.
module dsp_product_sampler
    import dsp_sampler_pkg::*;
#(
    parameter int NUM_CH        = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter bit AUTO_START    = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [NUM_CH*64-1:0] products,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 dropped
);

    localparam int FRAME_LEN = frame_len(NUM_CH);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);

    state_e               state_r;
    state_e               next_state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     nidx_s;
    logic [IDX_W-1:0]     ch_s;
    logic [IDX_W-1:0]     pos_s;
    logic [31:0]          shamt_s;
    logic [7:0]           csum_r;
    logic [NUM_CH*64-1:0] shadow_r;
    logic                 pending_r;
    logic                 frame_done_r;
    logic                 dropped_r;
    logic                 busy_r;
    logic                 trigger_s;
    logic                 cnt_last_s;
    logic                 idx_last_s;
    logic                 load_s;
    logic [7:0]           load_byte_s;
    logic [7:0]           next_byte_s;
    logic                 accepted_s;

    assign trigger_s  = start | pending_r;
    assign cnt_last_s = (cnt_r == CNT_LAST);
    assign idx_last_s = (idx_r == LAST_IDX);

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign dropped    = dropped_r;

    dsp_byte_tx u_tx (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load_s),
        .load_byte (load_byte_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .accepted  (accepted_s)
    );

    // Byte that follows the one currently presented; idx_r also counts body bytes before it.
    always_comb begin
        nidx_s  = idx_r + IDX_W'(1'b1);
        ch_s    = idx_r / IDX_W'(BYTES_PER_CH);
        pos_s   = idx_r % IDX_W'(BYTES_PER_CH);
        shamt_s = 32'd0;
        if (nidx_s == LAST_IDX) begin
            next_byte_s = csum_next(csum_r, out_data);
        end else if (pos_s == {IDX_W{1'b0}}) begin
            next_byte_s = 8'(ch_s);
        end else begin
            shamt_s     = 32'(ch_s) * 32'd64 + (32'(pos_s) - 32'd1) * 32'd8;
            next_byte_s = 8'(shadow_r >> shamt_s);
        end
    end

    // Sequencer next-state and byte-load decisions.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_byte_s  = 8'h00;
        case (state_r)
            IDLE: begin
                if (trigger_s) next_state_s = SETTLE;
                else           next_state_s = IDLE;
            end
            SETTLE: begin
                if (cnt_last_s) next_state_s = CAPTURE;
                else            next_state_s = SETTLE;
            end
            CAPTURE: begin
                next_state_s = SEND;
                load_s       = 1'b1;
                load_byte_s  = SYNC_BYTE;
            end
            SEND: begin
                // SEND is held through the frame_done cycle so busy covers it.
                if (frame_done_r) begin
                    next_state_s = IDLE;
                end else if (accepted_s && !idx_last_s) begin
                    load_s      = 1'b1;
                    load_byte_s = next_byte_s;
                end else begin
                    next_state_s = SEND;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Control state, trigger bookkeeping and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            pending_r    <= AUTO_START;
            frame_done_r <= 1'b0;
            dropped_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            busy_r       <= (next_state_s != IDLE);
            frame_done_r <= (state_r == SEND) && accepted_s && idx_last_s;
            if (state_r == IDLE && trigger_s) pending_r <= 1'b0;
            if (start && state_r != IDLE)     dropped_r <= 1'b1;
        end
    end

    // Settle counter, snapshot capture, byte index and running checksum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            csum_r   <= 8'h00;
            shadow_r <= {(NUM_CH*64){1'b0}};
        end else begin
            case (state_r)
                SETTLE: begin
                    if (cnt_last_s) cnt_r <= {CNT_W{1'b0}};
                    else            cnt_r <= cnt_r + CNT_W'(1'b1);
                end
                CAPTURE: begin
                    shadow_r <= products;
                    idx_r    <= {IDX_W{1'b0}};
                    csum_r   <= 8'h00;
                end
                SEND: begin
                    if (accepted_s && !idx_last_s) begin
                        idx_r  <= nidx_s;
                        csum_r <= csum_next(csum_r, out_data);
                    end
                end
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_product_sampler.sv
// Self-checking bench for dsp_product_sampler: directed vector table, randomized
// frames against a frame-building model, and the multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_dsp_product_sampler;

    localparam int NCH  = 5;
    localparam int NCH2 = 2;
    localparam int LEN  = NCH * 9 + 2;
    localparam int LAT  = 16 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn, start, out_ready, out_valid, busy, frame_done, dropped;
    logic [7:0]          out_data;
    logic [NCH*64-1:0]   products;
    logic                start2, ready2, valid2, busy2, done2, dropped2;
    logic [7:0]          data2;
    logic [NCH2*64-1:0]  products2;

    dsp_product_sampler #(.NUM_CH(NCH), .SETTLE_CYCLES(16), .AUTO_START(1'b1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .products(products),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .dropped(dropped)
    );

    dsp_product_sampler #(.NUM_CH(NCH2), .SETTLE_CYCLES(1), .AUTO_START(1'b0)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .products(products2),
        .out_data(data2), .out_valid(valid2), .out_ready(ready2),
        .busy(busy2), .frame_done(done2), .dropped(dropped2)
    );

    typedef struct {
        int         frame;
        int         pos;
        logic [7:0] exp;
    } vec_t;

    vec_t         vecs[16];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   got_q[$];
    logic [7:0]   exp_q[$];
    logic [7:0]   frame_a[$];
    logic [7:0]   frame_b[$];
    logic [511:0] snap;
    logic [7:0]   act;
    bit           any_act;
    bit           seen2;
    bit           done2_seen;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame straight from the format rules: sync, per channel index + LSB-first bytes, XOR.
    function automatic void model_frame(input int nch, input logic [511:0] p);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < nch; k++) begin
            exp_q.push_back(8'(k));
            for (int b = 0; b < 8; b++) exp_q.push_back(p[64*k + 8*b +: 8]);
        end
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
    endfunction

    task automatic compare_frame(input string tag);
        chk({tag, " length"}, 64'(got_q.size()), 64'(exp_q.size()));
        if (got_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("%s byte %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic randomize_products();
        for (int k = 0; k < NCH; k++) products[64*k +: 64] = {$urandom(), $urandom()};
    endtask

    // Runs one frame on the main instance; tick 1 is the cycle after the trigger cycle.
    task automatic run_frame(input string tag, input int rmode, input bit vary,
                             input bit pulse_settle, input bit start_on_done, input int abort_at);
        bit         seen_first = 1'b0;
        bit         done = 1'b0;
        bit         prev_stall = 1'b0;
        bit         prev_acc = 1'b0;
        logic [7:0] prev_data = 8'h00;
        got_q.delete();
        snap = 512'd0;
        for (int t = 1; t <= 2000 && !done; t++) begin
            tick();
            start = pulse_settle && (t == 5);
            if (rmode == 0)      out_ready = 1'b1;
            else if (rmode == 1) out_ready = ((t % 2) == 0);
            else                 out_ready = 1'($urandom_range(0, 1));
            if (t == 1) chk({tag, " busy after trigger"}, 64'(busy), 64'd1);
            if (pulse_settle && t == 6) chk({tag, " dropped after start in settle"}, 64'(dropped), 64'd1);
            if (prev_stall) begin
                chk({tag, " valid held in stall"}, 64'(out_valid), 64'd1);
                chk({tag, " data held in stall"}, 64'(out_data), 64'(prev_data));
            end
            if (!seen_first && out_valid) begin
                seen_first = 1'b1;
                chk({tag, " first byte latency"}, 64'(t), 64'(LAT));
                snap = 512'(products);
            end
            if (frame_done) begin
                done = 1'b1;
                chk({tag, " valid low at frame_done"}, 64'(out_valid), 64'd0);
                chk({tag, " busy at frame_done"}, 64'(busy), 64'd1);
                chk({tag, " checksum accepted just before frame_done"}, 64'(prev_acc), 64'd1);
                chk({tag, " bytes at frame_done"}, 64'(got_q.size()), 64'(LEN));
                if (start_on_done) start = 1'b1;
            end
            prev_acc = out_valid && out_ready;
            if (prev_acc) got_q.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (abort_at > 0 && got_q.size() == abort_at) begin
                resetn = 1'b0;
                #1;
                chk({tag, " valid after async reset"}, 64'(out_valid), 64'd0);
                chk({tag, " busy after async reset"}, 64'(busy), 64'd0);
                chk({tag, " data after async reset"}, 64'(out_data), 64'd0);
                return;
            end
            if (vary) randomize_products();
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: frame_done not seen, %0d bytes", tag, got_q.size());
        end
        tick();
        start = 1'b0;
        chk({tag, " frame_done is one pulse"}, 64'(frame_done), 64'd0);
        chk({tag, " idle after frame"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs = '{
            '{0, 0, 8'hA5}, '{0, 1, 8'h00}, '{0, 2, 8'h0A}, '{0, 3, 8'h1B},
            '{0, 4, 8'h00}, '{0, 9, 8'h00}, '{0, 10, 8'h01}, '{0, 19, 8'h02},
            '{0, 37, 8'h04}, '{0, 46, 8'hB0},
            '{1, 0, 8'hA5}, '{1, 19, 8'h02}, '{1, 20, 8'h11}, '{1, 27, 8'h88},
            '{1, 28, 8'h03}, '{1, 46, 8'h29}
        };
        resetn    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        products  = '0;
        start2    = 1'b0;
        ready2    = 1'b1;
        products2 = '0;
        products[63:0] = 64'h0000_0000_0000_1B0A;
        repeat (3) tick();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset frame_done", 64'(frame_done), 64'd0);
        chk("reset dropped", 64'(dropped), 64'd0);
        chk("reset dut2 out_valid", 64'(valid2), 64'd0);

        // Auto-start frame after reset release.
        resetn = 1'b1;
        run_frame("auto", 0, 1'b0, 1'b0, 1'b0, 0);
        model_frame(NCH, snap);
        compare_frame("auto");
        frame_a = got_q;
        chk("no dropped after auto frame", 64'(dropped), 64'd0);

        // Alternating ready with channel 2 populated.
        products = '0;
        products[191:128] = 64'h8877_6655_4433_2211;
        tick();
        start = 1'b1;
        run_frame("stall", 1, 1'b0, 1'b0, 1'b0, 0);
        model_frame(NCH, snap);
        compare_frame("stall");
        frame_b = got_q;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].frame == 0) act = (vecs[i].pos < frame_a.size()) ? frame_a[vecs[i].pos] : 8'hxx;
            else                    act = (vecs[i].pos < frame_b.size()) ? frame_b[vecs[i].pos] : 8'hxx;
            chk($sformatf("vector %0d frame %0d pos %0d", i, vecs[i].frame, vecs[i].pos),
                64'(act), 64'(vecs[i].exp));
        end

        // Randomized frames; odd runs also change products every cycle.
        for (int r = 0; r < 4; r++) begin
            randomize_products();
            tick();
            start = 1'b1;
            run_frame($sformatf("rand%0d", r), (r == 0) ? 0 : 2, 1'(r % 2), 1'b0, 1'b0, 0);
            model_frame(NCH, snap);
            compare_frame($sformatf("rand%0d", r));
        end

        // Start while busy: in SETTLE and on the frame_done cycle.
        randomize_products();
        tick();
        start = 1'b1;
        run_frame("drop", 0, 1'b0, 1'b1, 1'b1, 0);
        model_frame(NCH, snap);
        compare_frame("drop");
        any_act = 1'b0;
        repeat (30) begin
            tick();
            any_act = any_act | out_valid | busy;
        end
        chk("no second frame after dropped starts", 64'(any_act), 64'd0);
        chk("dropped sticky", 64'(dropped), 64'd1);

        // Reset mid-frame, then restart with start coinciding with the auto flag.
        tick();
        start = 1'b1;
        run_frame("abort", 0, 1'b0, 1'b0, 1'b0, 20);
        chk("dropped cleared by reset", 64'(dropped), 64'd0);
        tick();
        tick();
        resetn = 1'b1;
        start  = 1'b1;
        run_frame("restart", 0, 1'b0, 1'b0, 1'b0, 0);
        model_frame(NCH, snap);
        compare_frame("restart");
        any_act = 1'b0;
        repeat (30) begin
            tick();
            any_act = any_act | out_valid | busy;
        end
        chk("single trigger from start plus auto flag", 64'(any_act), 64'd0);
        chk("no dropped for start in idle", 64'(dropped), 64'd0);

        // One-cycle settle instance: A5 valid at t+3, busy through frame_done.
        products2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        chk("dut2 idle without start", 64'(busy2), 64'd0);
        start2 = 1'b1;
        got_q.delete();
        seen2      = 1'b0;
        done2_seen = 1'b0;
        snap       = 512'd0;
        for (int t = 1; t <= 200 && !done2_seen; t++) begin
            tick();
            start2 = 1'b0;
            chk($sformatf("dut2 busy at t+%0d", t), 64'(busy2), 64'd1);
            if (!seen2 && valid2) begin
                seen2 = 1'b1;
                chk("dut2 first byte latency", 64'(t), 64'd3);
                snap = 512'(products2);
            end
            if (done2) done2_seen = 1'b1;
            if (valid2 && ready2) got_q.push_back(data2);
            products2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        chk("dut2 frame_done seen", 64'(done2_seen), 64'd1);
        tick();
        chk("dut2 idle after frame", 64'(busy2), 64'd0);
        model_frame(NCH2, snap);
        compare_frame("settle1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
